renkon_linebuf_feed: RTL

Pixel feeder for the renkon padded line buffer. It reads one img_size x img_size feature map in row-major order from a single-port image memory with 1-cycle read latency, and starts the line buffer with the buf_req/buf_ack handshake. It then presents each pixel on buf_input in the same cycle the line buffer raises buf_ready, using a 2-entry prefetch FIFO to hide the memory latency. It sits between the image memory and the line-buffer input port.

---
 rtl/renkon_linebuf_feed.sv | 105 ++++++++++
 1 files changed

// File: rtl/renkon_linebuf_feed.sv
// renkon_linebuf_feed: streams a square feature map from image memory into the line buffer,
// hiding the 1-cycle read latency behind a 2-entry prefetch FIFO.
module renkon_linebuf_feed #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 10,
    parameter int AWIDTH = 12
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     feed_req,
    input  logic [AWIDTH-1:0]        feed_base,
    input  logic [LWIDTH-1:0]        img_size,
    output logic                     feed_ack,
    output logic                     feed_done,
    output logic                     feed_err,
    output logic [AWIDTH-1:0]        mem_addr,
    input  logic signed [DWIDTH-1:0] mem_rdata,
    output logic                     buf_req,
    input  logic                     buf_ack,
    input  logic                     buf_ready,
    output logic signed [DWIDTH-1:0] buf_input
);
    typedef enum logic [1:0] {S_WAIT, S_REQ, S_STREAM} state_t;
    state_t state;
    logic [AWIDTH-1:0] base, addr_q;
    logic [2*LWIDTH-1:0] total, read_cnt, pop_cnt, size_ext;
    logic signed [DWIDTH-1:0] f0, f1;
    logic [1:0] fifo_cnt;
    logic [2:0] credit;
    logic inflight, active, pop, underrun, issue, done;
    assign size_ext = {{LWIDTH{1'b0}}, img_size};
    assign active = state == S_REQ || state == S_STREAM;
    assign pop = active && buf_ready && fifo_cnt != 2'd0;
    assign underrun = active && buf_ready && fifo_cnt == 2'd0;
    assign done = pop && pop_cnt + 1'b1 == total;
    // Outstanding data after this cycle's pop; reads stop at 2 so the FIFO can never overflow.
    assign credit = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign issue = active && read_cnt < total && credit < 3'd2;
    assign mem_addr = issue ? base + read_cnt[AWIDTH-1:0] : addr_q;
    assign buf_input = fifo_cnt != 2'd0 ? f0 : '0;
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= S_WAIT;
            feed_ack <= 1'b1;
            feed_done <= 1'b0;
            feed_err <= 1'b0;
            buf_req <= 1'b0;
            base <= '0;
            addr_q <= '0;
            total <= '0;
            read_cnt <= '0;
            pop_cnt <= '0;
            inflight <= 1'b0;
            fifo_cnt <= '0;
            f0 <= '0;
            f1 <= '0;
        end else begin
            feed_done <= 1'b0;
            inflight <= issue;
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
            if (issue) begin
                addr_q <= mem_addr;
                read_cnt <= read_cnt + 1'b1;
            end
            if (pop) pop_cnt <= pop_cnt + 1'b1;
            if (underrun) feed_err <= 1'b1;
            // Head register shifts on pop; returning data lands in the first free slot.
            if (pop) f0 <= fifo_cnt == 2'd2 ? f1 : mem_rdata;
            else if (inflight && fifo_cnt == 2'd0) f0 <= mem_rdata;
            if (inflight && fifo_cnt == (pop ? 2'd2 : 2'd1)) f1 <= mem_rdata;
            case (state)
                S_WAIT: if (feed_req) begin
                    state <= S_REQ;
                    feed_ack <= 1'b0;
                    buf_req <= 1'b1;
                    base <= feed_base;
                    total <= size_ext * size_ext;
                    read_cnt <= '0;
                    pop_cnt <= '0;
                    fifo_cnt <= '0;
                    feed_err <= 1'b0;
                end
                S_REQ: if (done) begin
                    state <= S_WAIT;
                    feed_ack <= 1'b1;
                    feed_done <= 1'b1;
                    buf_req <= 1'b0;
                end else if (buf_ack) begin
                    state <= S_STREAM;
                    buf_req <= 1'b0;
                end
                S_STREAM: if (done) begin
                    state <= S_WAIT;
                    feed_ack <= 1'b1;
                    feed_done <= 1'b1;
                end
                default: begin
                    state <= S_WAIT;
                    feed_ack <= 1'b1;
                    buf_req <= 1'b0;
                end
            endcase
        end
    end
endmodule
